// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer counter/compare block.
package timer_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DIV_MAX   = 8;
  localparam int unsigned PRE_W     = 8;
  localparam int unsigned CNT_MAX_W = 128;

  // All-ones reset value for a compare register of width cnt_w, zero-extended
  // to the widest supported counter.
  function automatic logic [CNT_MAX_W-1:0] cmp_reset_val(input int unsigned cnt_w);
    logic [CNT_MAX_W-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < CNT_MAX_W; i++) begin
      if (i < cnt_w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 2^N prescaler: emits a one-cycle tick every 2^div_val active cycles.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             active,
  input  logic             div_en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;
  logic [3:0]       dv;
  logic [PRE_W:0]   term;
  logic             divide;

  // Saturated exponent, terminal count and next prescaler value.
  always_comb begin
    dv     = (32'(div_val) > DIV_MAX) ? 4'(DIV_MAX) : 4'(div_val);
    term   = ((PRE_W+1)'(1) << dv) - (PRE_W+1)'(1);
    divide = div_en && (dv != 4'd0);
    tick   = 1'b0;
    pre_d  = pre_q;
    if (active) begin
      // >= rather than == so a smaller div_val applied mid-count wraps at once
      if (!divide || ({1'b0, pre_q} >= term)) begin
        tick  = 1'b1;
        pre_d = '0;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
    if (!div_en) pre_d = '0;
  end

  // Prescaler count register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) pre_q <= '0;
    else        pre_q <= pre_d;
  end

endmodule

// File: rtl/timer_counter_cmp.sv
// Word-writable up-counter with compare match, prescaler, auto-reload,
// one-shot, debug halt and a maskable registered interrupt.
module timer_counter_cmp
  import timer_pkg::*;
#(
  parameter  int unsigned CNT_W  = 64,
  parameter  int unsigned DIV_W  = 4,
  localparam int unsigned NWORDS = CNT_W / WORD_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              timer_en,
  input  logic              div_en,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              auto_rld,
  input  logic              one_shot,
  input  logic              halt_req,
  input  logic              int_en,
  input  logic              int_clr,
  input  logic [NWORDS-1:0] wr_cnt_sel,
  input  logic [NWORDS-1:0] wr_cmp_sel,
  input  logic [31:0]       wr_data,
  output logic [CNT_W-1:0]  COUNTER_VALUE,
  output logic [CNT_W-1:0]  COMPARE_VALUE,
  output logic              int_st,
  output logic              tim_int,
  output logic              halt_ack
);

  localparam logic [CNT_MAX_W-1:0] CMP_RST_FULL = cmp_reset_val(CNT_W);
  localparam logic [CNT_W-1:0]     CMP_RST      = CMP_RST_FULL[CNT_W-1:0];

  logic             pre_timer_en;
  logic             done;
  logic             done_d;
  logic             fall;
  logic             active;
  logic             tick;
  logic             match;
  logic             int_st_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cmp_d;

  // Prescaler is forced to zero whenever the timer is off, which also
  // covers the clear on a timer_en falling edge.
  timer_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .active  (active),
    .div_en  (div_en & timer_en),
    .div_val (div_val),
    .tick    (tick)
  );

  // Control decode, next count/compare, done and interrupt status.
  always_comb begin
    fall     = pre_timer_en & ~timer_en;
    active   = timer_en & ~halt_ack & ~done;
    match    = (COUNTER_VALUE == COMPARE_VALUE);
    cnt_d    = COUNTER_VALUE;
    cmp_d    = COMPARE_VALUE;
    done_d   = done;
    int_st_d = int_st;

    if (fall) begin
      cnt_d = '0;
    end else if (tick) begin
      if (match && auto_rld)      cnt_d = '0;
      else if (match && one_shot) cnt_d = COUNTER_VALUE;
      else                        cnt_d = COUNTER_VALUE + CNT_W'(1);
    end

    // Written words replace the computed value; unwritten words keep it,
    // carry included.
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (wr_cnt_sel[i]) cnt_d[i*WORD_W +: WORD_W] = wr_data;
      if (wr_cmp_sel[i]) cmp_d[i*WORD_W +: WORD_W] = wr_data;
    end

    if (tick && match && one_shot && !auto_rld) done_d = 1'b1;
    if (fall || (|wr_cnt_sel))                  done_d = 1'b0;

    if (tick && match) int_st_d = 1'b1;
    else if (int_clr)  int_st_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_timer_en  <= 1'b0;
      halt_ack      <= 1'b0;
      done          <= 1'b0;
      COUNTER_VALUE <= '0;
      COMPARE_VALUE <= CMP_RST;
      int_st        <= 1'b0;
      tim_int       <= 1'b0;
    end else begin
      pre_timer_en  <= timer_en;
      halt_ack      <= halt_req;
      done          <= done_d;
      COUNTER_VALUE <= cnt_d;
      COMPARE_VALUE <= cmp_d;
      int_st        <= int_st_d;
      tim_int       <= int_st_d & int_en;
    end
  end

endmodule
